object_mux_collision: RTL and testbench

Pixel-stream consumer for the per-object sprite drawers in the VGA path. Each cycle it takes the registered `drawing_request`/RGB pairs from `NUM_OBJ` drawers and selects one pixel colour by fixed priority, falling back to a background colour. It also detects frog-versus-hazard overlap and reports one collision event per frame to the game logic.

---
 rtl/vga_pkg.sv | 19 +
 rtl/object_mux_collision_priority_select.sv | 24 ++
 rtl/object_mux_collision.sv | 104 ++++++++++
 tb/tb_object_mux_collision.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA-path types and constants used by the sprite drawers and the object mux.
package vga_pkg;

  localparam int RGB_W   = 8;
  localparam int MAX_OBJ = 8;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam int OBJ_FROG   = 0;
  localparam int OBJ_CAR    = 1;
  localparam int OBJ_TRUCK  = 2;
  localparam int OBJ_SNAKE  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mux_state_t;

endpackage

// File: rtl/object_mux_collision_priority_select.sv
// Lowest-index-wins encoder over the per-object draw requests.
module priority_select
  import vga_pkg::*;
#(
  parameter int NUM_OBJ = 4
) (
  input  logic [NUM_OBJ-1:0] req,
  output logic [2:0]         idx,
  output logic               valid
);

  // Scanning downward lets the lowest set index overwrite the rest.
  always_comb begin
    idx   = 3'(NUM_OBJ);
    valid = 1'b0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_mux_collision.sv
// Priority pixel mux for the sprite drawers plus per-frame frog/hazard collision reporting.
module object_mux_collision
  import vga_pkg::*;
#(
  parameter int                 NUM_OBJ     = 4,
  parameter logic [NUM_OBJ-1:0] HAZARD_MASK = {{(NUM_OBJ-1){1'b1}}, 1'b0}
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     startOfFrame,
  input  logic [NUM_OBJ-1:0]       drawing_request,
  input  rgb_t [NUM_OBJ-1:0]       obj_RGB,
  input  rgb_t                     bg_RGB,
  input  logic                     clr_count,
  output rgb_t                     mVGA_RGB,
  output logic [2:0]               top_index,
  output logic                     collision,
  output logic [NUM_OBJ-1:0]       collision_mask,
  output logic [7:0]               hit_count
);

  localparam logic [NUM_OBJ-1:0] HAZ_ONLY = HAZARD_MASK & ~{{(NUM_OBJ-1){1'b0}}, 1'b1};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]         sel_idx_p0;
  logic               sel_vld_p0;
  rgb_t               sel_rgb_p0;
  logic [NUM_OBJ-1:0] hit_bits_p0;
  logic               hit_now_p0;
  logic               report_p0;
  logic               frame_hit;
  logic [NUM_OBJ-1:0] frame_mask;
  mux_state_t         state_q, state_d;

  priority_select #(.NUM_OBJ(NUM_OBJ)) u_prio (
    .req   (drawing_request),
    .idx   (sel_idx_p0),
    .valid (sel_vld_p0)
  );

  always_comb begin
    sel_rgb_p0 = bg_RGB;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (sel_vld_p0 && (sel_idx_p0 == 3'(i))) sel_rgb_p0 = obj_RGB[i];
    end
  end

  assign hit_bits_p0 = drawing_request & HAZ_ONLY & {NUM_OBJ{drawing_request[0]}};
  assign hit_now_p0  = |hit_bits_p0;
  assign report_p0   = (state_q == ST_RUN) && startOfFrame;

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_IDLE) && startOfFrame) state_d = ST_RUN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // p0 -> p1: registered pixel output
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mVGA_RGB  <= '0;
      top_index <= '0;
    end else begin
      mVGA_RGB  <= sel_rgb_p0;
      top_index <= sel_idx_p0;
    end
  end

  // Frame accumulators; a frame boundary reloads so the first pixel belongs to the new frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_hit  <= 1'b0;
      frame_mask <= '0;
    end else if (startOfFrame) begin
      frame_hit  <= hit_now_p0;
      frame_mask <= hit_bits_p0;
    end else if (state_q == ST_RUN) begin
      frame_hit  <= frame_hit | hit_now_p0;
      frame_mask <= frame_mask | hit_bits_p0;
    end
  end

  // p0 -> p1: per-frame report, clear beats increment
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      collision      <= 1'b0;
      collision_mask <= '0;
      hit_count      <= '0;
    end else begin
      collision <= report_p0 && frame_hit;
      if (report_p0) collision_mask <= frame_mask;
      if (clr_count)                   hit_count <= '0;
      else if (report_p0 && frame_hit) hit_count <= sat_inc(hit_count);
    end
  end

endmodule

// File: tb/tb_object_mux_collision.sv
// Randomized and directed bench for object_mux_collision with a frame-log reference model.
module tb_object_mux_collision;

  localparam int NUM_OBJ = 4;

  logic                    CLK = 1'b0;
  logic                    RESET = 1'b1;
  logic                    startOfFrame = 1'b0;
  logic [NUM_OBJ-1:0]      drawing_request = '0;
  logic [NUM_OBJ-1:0][7:0] obj_RGB = '0;
  logic [7:0]              bg_RGB = '0;
  logic                    clr_count = 1'b0;
  logic [7:0]              mVGA_RGB;
  logic [2:0]              top_index;
  logic                    collision;
  logic [NUM_OBJ-1:0]      collision_mask;
  logic [7:0]              hit_count;

  object_mux_collision #(.NUM_OBJ(NUM_OBJ), .HAZARD_MASK(4'b1110)) dut (
    .CLK(CLK), .RESET(RESET), .startOfFrame(startOfFrame),
    .drawing_request(drawing_request), .obj_RGB(obj_RGB), .bg_RGB(bg_RGB),
    .clr_count(clr_count), .mVGA_RGB(mVGA_RGB), .top_index(top_index),
    .collision(collision), .collision_mask(collision_mask), .hit_count(hit_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is kept as a log of request vectors and judged whole at the boundary.
  logic [7:0]         m_rgb;
  int                 m_idx;
  logic               m_coll;
  logic [NUM_OBJ-1:0] m_mask;
  int                 m_count;
  bit                 running;
  logic [NUM_OBJ-1:0] frame_log[$];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_rgb = 8'h00; m_idx = 0; m_coll = 1'b0; m_mask = '0; m_count = 0;
      running = 1'b0; frame_log.delete();
    end else begin
      int w;
      logic [NUM_OBJ-1:0] acc;
      w = NUM_OBJ;
      for (int i = NUM_OBJ - 1; i >= 0; i--) if (drawing_request[i]) w = i;
      m_idx = w;
      m_rgb = (w == NUM_OBJ) ? bg_RGB : obj_RGB[w];
      m_coll = 1'b0;
      if (startOfFrame) begin
        if (running) begin
          acc = '0;
          foreach (frame_log[k]) if (frame_log[k][0]) acc |= frame_log[k] & 4'b1110;
          m_coll = (acc != 0);
          m_mask = acc;
          if (m_coll && m_count < 255) m_count++;
        end
        running = 1'b1;
        frame_log.delete();
        frame_log.push_back(drawing_request);
      end else if (running) begin
        frame_log.push_back(drawing_request);
      end
      if (clr_count) m_count = 0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("rgb", 32'(mVGA_RGB), 32'(m_rgb));
      chk("top_index", 32'(top_index), 32'(m_idx));
      chk("collision", 32'(collision), 32'(m_coll));
      chk("collision_mask", 32'(collision_mask), 32'(m_mask));
      chk("hit_count", 32'(hit_count), 32'(m_count));
    end
  end

  task automatic apply(input logic sof, input logic [NUM_OBJ-1:0] req, input logic clr);
    @(negedge CLK); #1;
    startOfFrame = sof; drawing_request = req; clr_count = clr;
  endtask

  task automatic settle();
    @(posedge CLK); #1;
  endtask

  initial begin
    @(negedge CLK); @(negedge CLK); #1;
    chk("reset_rgb", 32'(mVGA_RGB), 32'h00);
    chk("reset_count", 32'(hit_count), 32'h00);
    RESET = 1'b0;
    chk_en = 1'b1;

    obj_RGB[1] = 8'hD4; obj_RGB[2] = 8'h1C; obj_RGB[0] = 8'h3F; obj_RGB[3] = 8'hE0;
    apply(1'b0, 4'b0110, 1'b0); settle();
    chk("prio_rgb", 32'(mVGA_RGB), 32'hD4);
    chk("prio_idx", 32'(top_index), 32'd1);

    bg_RGB = 8'h92;
    apply(1'b0, 4'b0000, 1'b0); settle();
    chk("bg_rgb", 32'(mVGA_RGB), 32'h92);
    chk("bg_idx", 32'(top_index), 32'd4);

    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("idle_sof_no_pulse", 32'(collision), 32'd0);
    repeat (3) apply(1'b0, 4'b0000, 1'b0);
    apply(1'b0, 4'b0101, 1'b0);
    apply(1'b0, 4'b0000, 1'b0);
    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("single_coll", 32'(collision), 32'd1);
    chk("single_mask", 32'(collision_mask), 32'b0100);
    chk("single_count", 32'(hit_count), 32'd1);
    apply(1'b0, 4'b0000, 1'b0); settle();
    chk("pulse_one_cycle", 32'(collision), 32'd0);
    chk("mask_held", 32'(collision_mask), 32'b0100);
    apply(1'b0, 4'b0010, 1'b0);
    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("clean_coll", 32'(collision), 32'd0);
    chk("clean_mask", 32'(collision_mask), 32'd0);
    chk("clean_count", 32'(hit_count), 32'd1);

    apply(1'b1, 4'b1001, 1'b0); settle();
    chk("edge_not_now", 32'(collision), 32'd0);
    apply(1'b0, 4'b0001, 1'b0);
    apply(1'b0, 4'b1100, 1'b0);
    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("edge_next", 32'(collision), 32'd1);
    chk("edge_mask", 32'(collision_mask), 32'b1000);
    chk("edge_count", 32'(hit_count), 32'd2);
    apply(1'b0, 4'b0001, 1'b0);
    apply(1'b0, 4'b1100, 1'b0);
    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("frog_or_haz_alone", 32'(collision), 32'd0);
    chk("alone_count", 32'(hit_count), 32'd2);

    repeat (261) apply(1'b1, 4'b0101, 1'b0);
    settle();
    chk("saturate", 32'(hit_count), 32'd255);
    apply(1'b1, 4'b0101, 1'b1); settle();
    chk("clr_wins", 32'(hit_count), 32'd0);
    chk("clr_coll", 32'(collision), 32'd1);

    apply(1'b0, 4'b0101, 1'b0);
    apply(1'b0, 4'b0000, 1'b0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_rgb", 32'(mVGA_RGB), 32'h00);
    chk("rst_mask", 32'(collision_mask), 32'd0);
    chk("rst_count", 32'(hit_count), 32'd0);
    chk("rst_idx", 32'(top_index), 32'd0);
    apply(1'b0, 4'b0101, 1'b0);
    @(negedge CLK); #1 RESET = 1'b0;
    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("post_rst_first_sof", 32'(collision), 32'd0);
    apply(1'b0, 4'b0101, 1'b0);
    apply(1'b1, 4'b0000, 1'b0); settle();
    chk("post_rst_second_sof", 32'(collision), 32'd1);
    chk("post_rst_count", 32'(hit_count), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      obj_RGB = $urandom;
      bg_RGB  = 8'($urandom);
      apply(($urandom_range(0, 5) == 0), 4'($urandom), ($urandom_range(0, 63) == 0));
    end
    apply(1'b0, 4'b0000, 1'b0);
    @(negedge CLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
